// File: rtl/mac_operand_feeder_if.sv
// Operand/result bundle between the operand streamers, mac_operand_feeder and the 36-tap MAC.
// Master is the streamer/MAC side; slave is the feeder.
interface mac_operand_feeder_if #(
  parameter int unsigned IN_WIDTH          = 16,
  parameter int unsigned ACCUMULATOR_WIDTH = 32,
  parameter int unsigned NUM_TAPS          = 36
);
  logic signed [IN_WIDTH-1:0]          i_in;
  logic signed [IN_WIDTH-1:0]          k_in;
  logic                                in_valid;
  logic                                in_ready;
  logic                                in_last;
  logic [NUM_TAPS-1:0][IN_WIDTH-1:0]   mac_i_out;
  logic [NUM_TAPS-1:0][IN_WIDTH-1:0]   mac_k_out;
  logic signed [ACCUMULATOR_WIDTH-1:0] mac_result_in;
  logic signed [ACCUMULATOR_WIDTH-1:0] result_out;
  logic                                result_valid;
  logic                                result_ready;

  modport master (
    output i_in, k_in, in_valid, in_last, mac_result_in, result_ready,
    input  in_ready, mac_i_out, mac_k_out, result_out, result_valid
  );

  modport slave (
    input  i_in, k_in, in_valid, in_last, mac_result_in, result_ready,
    output in_ready, mac_i_out, mac_k_out, result_out, result_valid
  );
endinterface

// File: rtl/mac_operand_feeder.sv
// Packs operand pairs into 36-tap MAC operand registers, waits out the MAC latency, returns result.
// Optional macro FEEDER_ZERO_PAD_EN: in_last ends a short dot product and zeroes the remaining taps.
module mac_operand_feeder #(
  parameter int unsigned IN_WIDTH          = 16,
  parameter int unsigned ACCUMULATOR_WIDTH = 32,
  parameter int unsigned NUM_TAPS          = 36,
  parameter int unsigned MAC_LATENCY       = 3
) (
  input logic                 clk,
  input logic                 rst_in,
  mac_operand_feeder_if.slave bus
);
  localparam int unsigned CntW = $clog2(NUM_TAPS);
  localparam int unsigned LatW = $clog2(MAC_LATENCY + 1);
  localparam logic [CntW-1:0] LastTap = CntW'(NUM_TAPS - 1);
  localparam logic [LatW-1:0] LatDone = LatW'(MAC_LATENCY);

  typedef enum logic [1:0] {StFill, StWait, StHold} state_e;

  state_e                               r_state, w_state_next;
  logic [CntW-1:0]                      r_tap_cnt, w_tap_cnt_next;
  logic [LatW-1:0]                      r_lat_cnt, w_lat_cnt_next;
  logic [NUM_TAPS-1:0][IN_WIDTH-1:0]    r_i_taps, w_i_taps_next;
  logic [NUM_TAPS-1:0][IN_WIDTH-1:0]    r_k_taps, w_k_taps_next;
  logic signed [ACCUMULATOR_WIDTH-1:0]  r_result, w_result_next;
  // Keeps in_ready low while reset is held and until the first edge after release.
  logic                                 r_run;
  logic                                 w_fire;
  logic                                 w_short_last;

`ifdef FEEDER_ZERO_PAD_EN
  assign w_short_last = bus.in_last;
`else
  logic w_unused_in_last;
  assign w_unused_in_last = bus.in_last;
  assign w_short_last     = 1'b0;
`endif

  assign w_fire = (r_state == StFill) && r_run && bus.in_valid;

  always_comb begin
    w_state_next   = r_state;
    w_tap_cnt_next = r_tap_cnt;
    w_lat_cnt_next = r_lat_cnt;
    w_i_taps_next  = r_i_taps;
    w_k_taps_next  = r_k_taps;
    w_result_next  = r_result;
    unique case (r_state)
      StFill: begin
        if (w_fire) begin
          w_i_taps_next[r_tap_cnt] = bus.i_in;
          w_k_taps_next[r_tap_cnt] = bus.k_in;
          if ((r_tap_cnt == LastTap) || w_short_last) begin
            w_tap_cnt_next = '0;
            w_lat_cnt_next = '0;
            w_state_next   = StWait;
          end else begin
            w_tap_cnt_next = r_tap_cnt + 1'b1;
          end
          // Short dot product: taps beyond the last written one contribute nothing.
          for (int unsigned t = 0; t < NUM_TAPS; t++) begin
            if (w_short_last && (CntW'(t) > r_tap_cnt)) begin
              w_i_taps_next[t] = '0;
              w_k_taps_next[t] = '0;
            end
          end
        end
      end
      StWait: begin
        if (r_lat_cnt == LatDone) begin
          w_result_next = bus.mac_result_in;
          w_state_next  = StHold;
        end else begin
          w_lat_cnt_next = r_lat_cnt + 1'b1;
        end
      end
      StHold: begin
        if (bus.result_ready) begin
          w_state_next = StFill;
        end
      end
      default: w_state_next = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      r_state   <= StFill;
      r_tap_cnt <= '0;
      r_lat_cnt <= '0;
      r_i_taps  <= '0;
      r_k_taps  <= '0;
      r_result  <= '0;
      r_run     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_tap_cnt <= w_tap_cnt_next;
      r_lat_cnt <= w_lat_cnt_next;
      r_i_taps  <= w_i_taps_next;
      r_k_taps  <= w_k_taps_next;
      r_result  <= w_result_next;
      r_run     <= 1'b1;
    end
  end

  assign bus.in_ready     = (r_state == StFill) && r_run;
  assign bus.result_valid = (r_state == StHold);
  assign bus.result_out   = r_result;
  assign bus.mac_i_out    = r_i_taps;
  assign bus.mac_k_out    = r_k_taps;
endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder with a 3-stage behavioural MAC on the operand outputs.
// Expectations for the short dot product depend on FEEDER_ZERO_PAD_EN.
module tb_mac_operand_feeder;
  localparam int unsigned IW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned NT = 36;

  logic clk;
  logic rst_in;
  int   n_total;
  int   n_bad;

  mac_operand_feeder_if #(.IN_WIDTH(IW), .ACCUMULATOR_WIDTH(AW), .NUM_TAPS(NT)) bus ();

  mac_operand_feeder #(
    .IN_WIDTH(IW), .ACCUMULATOR_WIDTH(AW), .NUM_TAPS(NT), .MAC_LATENCY(3)
  ) u_dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: combinational dot product, then three register stages.
  function automatic logic [AW-1:0] dot(input logic [NT-1:0][IW-1:0] a,
                                        input logic [NT-1:0][IW-1:0] b);
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] ai;
    logic signed [AW-1:0] bi;
    acc = '0;
    for (int t = 0; t < NT; t++) begin
      ai = $signed(a[t]);
      bi = $signed(b[t]);
      acc = acc + ai * bi;
    end
    return acc;
  endfunction

  logic [AW-1:0] mac_s1, mac_s2, mac_s3;
  always @(posedge clk) begin
    mac_s1 <= dot(bus.mac_i_out, bus.mac_k_out);
    mac_s2 <= mac_s1;
    mac_s3 <= mac_s2;
  end
  assign bus.mac_result_in = mac_s3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair; returns at #1 after the edge that accepted it.
  task automatic push(input int i, input int k, input logic last, input int gap);
    int   guard;
    logic rdy;
    guard = 0;
    bus.i_in     = IW'(i);
    bus.k_in     = IW'(k);
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    forever begin
      rdy = bus.in_ready;
      tick();
      if (rdy) break;
      guard++;
      if (guard > 200) begin
        check("push_ready", rdy, 1);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    for (int g = 0; g < gap; g++) tick();
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp);
    int   n;
    logic rdy_seen;
    n = 0;
    rdy_seen = 1'b0;
    while (!bus.result_valid && n < 20) begin
      rdy_seen = rdy_seen | bus.in_ready;
      tick();
      n++;
    end
    check({tag, "_valid"}, bus.result_valid, 1);
    check({tag, "_value"}, bus.result_out, exp);
    check({tag, "_rdy_low"}, rdy_seen | bus.in_ready, 0);
  endtask

  logic        seen;
  logic [31:0] held;

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_in  = 1'b1;
    bus.i_in = '0;
    bus.k_in = '0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.result_ready = 1'b1;

    repeat (3) tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_res_valid", bus.result_valid, 0);
    check("rst_res_out", bus.result_out, 0);
    check("rst_taps", {31'd0, (|bus.mac_i_out) | (|bus.mac_k_out)}, 0);
    rst_in = 1'b0;
    tick();
    check("post_rst_ready", bus.in_ready, 1);

    // All ones: exact latency and single-cycle valid with result_ready high.
    for (int j = 0; j < NT; j++) push(1, 1, 1'b0, 0);
    check("t1_wait_ready", bus.in_ready, 0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("t1_valid_e%0d", c), bus.result_valid, (c == 4) ? 1 : 0);
    end
    check("t1_value", bus.result_out, 32'd36);
    tick();
    check("t1_valid_drop", bus.result_valid, 0);
    check("t1_ready_back", bus.in_ready, 1);

    // Ramp with random gaps: sum 0..35 = 630.
    for (int j = 0; j < NT; j++) push(j, 1, 1'b0, int'($urandom_range(0, 2)));
    wait_result("t2", 32'd630);
    tick();

    // Negative operands: 36 * -6 = -216.
    for (int j = 0; j < NT; j++) push(-2, 3, 1'b0, 0);
    wait_result("t3", 32'hFFFF_FF28);
    tick();

    // Reset during WAIT drops the result and clears the taps.
    for (int j = 0; j < NT; j++) push(3, 1, 1'b0, 0);
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("t5_rst_valid", bus.result_valid, 0);
    check("t5_rst_taps", {31'd0, (|bus.mac_i_out) | (|bus.mac_k_out)}, 0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen = seen | bus.result_valid;
    end
    check("t5_no_result", seen, 0);
    check("t5_ready", bus.in_ready, 1);
    for (int j = 0; j < NT; j++) push(j, 2, 1'b0, 0);
    wait_result("t5", 32'd1260);
    tick();

    // Back-pressure in HOLD with in_valid high; nothing may be consumed.
    bus.result_ready = 1'b0;
    for (int j = 0; j < NT; j++) push(2, 5, 1'b0, 0);
    wait_result("t4", 32'd360);
    held = bus.result_out;
    bus.i_in = IW'(5);
    bus.k_in = IW'(5);
    bus.in_valid = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen = seen | bus.in_ready | !bus.result_valid | (bus.result_out != held);
    end
    check("t4_hold_stable", seen, 0);
    check("t4_hold_value", bus.result_out, 32'd360);
    bus.in_valid = 1'b0;
    bus.result_ready = 1'b1;
    tick();
    check("t4_release", bus.result_valid, 0);
    for (int j = 0; j < NT; j++) push(1, 1, 1'b0, 0);
    wait_result("t4_next", 32'd36);
    tick();

    // Short dot product: 10 pairs of 2*2, stale taps are all 1.
    for (int j = 0; j < 10; j++) push(2, 2, (j == 9), 0);
`ifdef FEEDER_ZERO_PAD_EN
    check("t6_pad_tap10", bus.mac_i_out[10], 0);
    check("t6_pad_tap35", bus.mac_k_out[35], 0);
    wait_result("t6", 32'd40);
    tick();
`else
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen = seen | bus.result_valid | !bus.in_ready;
    end
    check("t6_no_early", seen, 0);
    for (int j = 10; j < NT; j++) push(2, 2, 1'b0, 0);
    wait_result("t6", 32'd144);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
